binary_game_round_ctrl: RTL and testbench

//  Round sequencer for the binary number game. Runs the 4-bit Generators block for a short spin,

---
 rtl/binary_game_pkg.sv | 24 ++
 rtl/binary_game_round_ctrl_timer.sv | 27 ++
 rtl/binary_game_round_ctrl.sv | 157 +++++++++++++++
 tb/tb_binary_game_round_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_game_pkg.sv
// Shared types, default widths and the saturating adder for the binary game round controller.
package binary_game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAW  = 3'd1,
    WAIT  = 3'd2,
    JUDGE = 3'd3,
    DONE  = 3'd4
  } game_state_t;

  localparam int DEF_NUM_W   = 4;
  localparam int DEF_SCORE_W = 4;

  // Adds inc to score and clamps at max_val instead of wrapping.
  function automatic int unsigned sat_add(input int unsigned score,
                                          input int unsigned inc,
                                          input int unsigned max_val);
    int unsigned sum;
    sum = score + inc;
    return (sum > max_val) ? max_val : sum;
  endfunction

endpackage

// File: rtl/binary_game_round_ctrl_timer.sv
// game_round_timer: per-round countdown. Load has priority over decrement; stops at zero.
module game_round_timer #(
  parameter int TIME_LIMIT = 1000,
  parameter int TW         = $clog2(TIME_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  output logic [TW-1:0] count,
  output logic          zero
);

  // Down-counter: reload at round start, count down while the player thinks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= TW'(TIME_LIMIT);
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

  // Terminal-count flag.
  assign zero = (count == '0);

endmodule

// File: rtl/binary_game_round_ctrl.sv
// binary_game_round_ctrl: round sequencer for the binary number game.
// Spins the generator, latches the target, times the player's guess, scores, repeats.
// Optional feature macro: GAME_STREAK_BONUS_EN (adds streak counter/port and streak bonus).
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   DRAW  | generator enabled for DRAW_CYCLES cycles
//   WAIT  | target shown, countdown running, waiting for submit
//   JUDGE | one cycle, result pulse out, score/round update
//   DONE  | game over, score held, waiting for start
module binary_game_round_ctrl
  import binary_game_pkg::*;
#(
  parameter int NUM_W       = DEF_NUM_W,
  parameter int ROUNDS      = 8,
  parameter int TIME_LIMIT  = 1000,
  parameter int DRAW_CYCLES = 3,
  parameter int SCORE_W     = DEF_SCORE_W,
  localparam int TW = $clog2(TIME_LIMIT + 1),
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
  localparam int DW = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_W-1:0]   gen_result,
  input  logic [NUM_W-1:0]   guess,
  input  logic               submit,
  output logic               gen_enable,
  output logic [NUM_W-1:0]   target,
  output logic               target_valid,
  output logic [TW-1:0]      timer,
  output logic [RW-1:0]      round_idx,
  output logic [SCORE_W-1:0] score,
  output logic               result_ok,
  output logic               result_fail,
`ifdef GAME_STREAK_BONUS_EN
  output logic [1:0]         streak,
`endif
  output logic               game_over
);

  localparam int unsigned SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;

  game_state_t   state, state_nxt;
  logic [DW-1:0] draw_cnt;
  logic          timer_load, timer_dec, timer_zero;
  logic          last_round, new_game;

  assign last_round = (round_idx == RW'(ROUNDS - 1));
  assign new_game   = ((state == IDLE) || (state == DONE)) && start;

  game_round_timer #(.TIME_LIMIT(TIME_LIMIT), .TW(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .dec   (timer_dec),
    .count (timer),
    .zero  (timer_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and timer control; submit takes priority over timeout in WAIT.
  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = DRAW;
      DRAW:  if (draw_cnt == DW'(DRAW_CYCLES - 1)) begin
               state_nxt  = WAIT;
               timer_load = 1'b1;
             end
      WAIT:  if (submit || timer_zero) state_nxt = JUDGE;
             else                      timer_dec = 1'b1;
      JUDGE: state_nxt = last_round ? DONE : DRAW;
      DONE:  if (start) state_nxt = DRAW;
      default: state_nxt = IDLE;
    endcase
  end

  // Level outputs decoded straight from state so reset clears them without a clock.
  assign gen_enable   = (state == DRAW);
  assign target_valid = (state == WAIT);
  assign game_over    = (state == DONE);

  // Draw-length counter, idle at zero outside DRAW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      draw_cnt <= '0;
    else if ((state == DRAW) && (draw_cnt != DW'(DRAW_CYCLES - 1)))
      draw_cnt <= draw_cnt + 1'b1;
    else
      draw_cnt <= '0;
  end

  // Latch the generator value on the edge that leaves DRAW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      target <= '0;
    else if ((state == DRAW) && (state_nxt == WAIT))
      target <= gen_result;
  end

  // Judge the guess on the WAIT exit edge so the pulses are high exactly during JUDGE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_ok   <= 1'b0;
      result_fail <= 1'b0;
    end else begin
      result_ok   <= (state == WAIT) && submit && (guess == target);
      result_fail <= (state == WAIT) && (submit ? (guess != target) : timer_zero);
    end
  end

  // Score, round index and (optionally) streak bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score     <= '0;
      round_idx <= '0;
`ifdef GAME_STREAK_BONUS_EN
      streak    <= 2'd0;
`endif
    end else if (new_game) begin
      score     <= '0;
      round_idx <= '0;
`ifdef GAME_STREAK_BONUS_EN
      streak    <= 2'd0;
`endif
    end else if (state == JUDGE) begin
      if (!last_round)
        round_idx <= round_idx + 1'b1;
`ifdef GAME_STREAK_BONUS_EN
      if (result_ok) begin
        if (streak == 2'd2) begin
          score  <= SCORE_W'(sat_add(32'(score), 32'd2, SCORE_MAX));
          streak <= 2'd0;
        end else begin
          score  <= SCORE_W'(sat_add(32'(score), 32'd1, SCORE_MAX));
          streak <= streak + 2'd1;
        end
      end else begin
        streak <= 2'd0;
      end
`else
      if (result_ok)
        score <= SCORE_W'(sat_add(32'(score), 32'd1, SCORE_MAX));
`endif
    end
  end

endmodule

// File: tb/tb_binary_game_round_ctrl.sv
// Self-checking bench for binary_game_round_ctrl: directed game scenarios with random
// targets, guesses and response delays, checked against a round-level score model.
module tb_binary_game_round_ctrl;

  localparam int TL = 16;
`ifdef GAME_STREAK_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, submit;
  logic [3:0] gen_result, guess;

  logic       a_gen_enable, a_target_valid, a_result_ok, a_result_fail, a_game_over;
  logic [3:0] a_target, a_score;
  logic [4:0] a_timer;
  logic [1:0] a_round_idx;
  logic       b_gen_enable, b_target_valid, b_result_ok, b_result_fail, b_game_over;
  logic [3:0] b_target;
  logic [1:0] b_score;
  logic [4:0] b_timer;
  logic [2:0] b_round_idx;
`ifdef GAME_STREAK_BONUS_EN
  logic [1:0] a_streak, b_streak, o_streak;
`endif

  int vectors = 0;
  int miscompares = 0;

  // sel picks which instance is observed: 0 = 4 rounds / 4-bit score, 1 = 8 rounds / 2-bit score
  bit         sel = 1'b0;
  logic       o_gen_enable, o_target_valid, o_result_ok, o_result_fail, o_game_over;
  logic [3:0] o_target, o_score;
  logic [4:0] o_timer;
  logic [2:0] o_round;

  // reference model of the game at round granularity
  int         m_score, m_round, m_streak;
  logic [3:0] m_target;

  always #5 clk = ~clk;

  binary_game_round_ctrl #(.NUM_W(4), .ROUNDS(4), .TIME_LIMIT(TL), .DRAW_CYCLES(3), .SCORE_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .gen_result(gen_result), .guess(guess), .submit(submit),
    .gen_enable(a_gen_enable), .target(a_target), .target_valid(a_target_valid), .timer(a_timer),
    .round_idx(a_round_idx), .score(a_score), .result_ok(a_result_ok), .result_fail(a_result_fail),
`ifdef GAME_STREAK_BONUS_EN
    .streak(a_streak),
`endif
    .game_over(a_game_over));

  binary_game_round_ctrl #(.NUM_W(4), .ROUNDS(8), .TIME_LIMIT(TL), .DRAW_CYCLES(3), .SCORE_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .gen_result(gen_result), .guess(guess), .submit(submit),
    .gen_enable(b_gen_enable), .target(b_target), .target_valid(b_target_valid), .timer(b_timer),
    .round_idx(b_round_idx), .score(b_score), .result_ok(b_result_ok), .result_fail(b_result_fail),
`ifdef GAME_STREAK_BONUS_EN
    .streak(b_streak),
`endif
    .game_over(b_game_over));

  assign o_gen_enable   = sel ? b_gen_enable   : a_gen_enable;
  assign o_target_valid = sel ? b_target_valid : a_target_valid;
  assign o_result_ok    = sel ? b_result_ok    : a_result_ok;
  assign o_result_fail  = sel ? b_result_fail  : a_result_fail;
  assign o_game_over    = sel ? b_game_over    : a_game_over;
  assign o_target       = sel ? b_target       : a_target;
  assign o_score        = sel ? {2'b00, b_score} : a_score;
  assign o_timer        = sel ? b_timer        : a_timer;
  assign o_round        = sel ? b_round_idx    : {1'b0, a_round_idx};
`ifdef GAME_STREAK_BONUS_EN
  assign o_streak       = sel ? b_streak       : a_streak;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_clear();
    m_score  = 0;
    m_round  = 0;
    m_streak = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
  endtask

  // Plays one round starting in the first DRAW cycle; ends in the cycle after JUDGE.
  // delay < 0 means no submit (timeout). noise pulses submit in DRAW and start in WAIT.
  task automatic play_round(input int delay, input bit correct, input bit noise,
                            input bit force_val, input logic [3:0] fval, input logic [3:0] wrong);
    logic [3:0] g, gs;
    bit ok, last;
    int inc, rounds, smax;
    rounds = sel ? 8 : 4;
    smax   = sel ? 3 : 15;
    g = 4'h0;
    for (int i = 0; i < 3; i++) begin
      check("draw_gen_enable", 32'(o_gen_enable), 32'd1);
      if (noise && i == 0) begin
        submit = 1'b1;
        guess  = 4'($urandom);
      end
      g = (force_val && i == 2) ? fval : 4'($urandom);
      gen_result = g;
      tick();
      submit = 1'b0;
      gen_result = 4'($urandom);
    end
    m_target = g;
    check("wait_gen_enable", 32'(o_gen_enable), 32'd0);
    check("wait_target_valid", 32'(o_target_valid), 32'd1);
    check("target", 32'(o_target), 32'(m_target));
    start = noise;
    if (delay < 0) begin
      for (int c = 0; c <= TL; c++) begin
        check("timeout_timer", 32'(o_timer), 32'(TL - c));
        tick();
        start = 1'b0;
      end
      ok = 1'b0;
    end else begin
      for (int c = 0; c < delay; c++) begin
        check("wait_timer", 32'(o_timer), 32'(TL - c));
        tick();
        start = 1'b0;
      end
      check("submit_timer", 32'(o_timer), 32'(TL - delay));
      gs = correct ? m_target : wrong;
      if (!correct && gs == m_target) gs = ~m_target;
      guess  = gs;
      submit = 1'b1;
      tick();
      submit = 1'b0;
      start  = 1'b0;
      ok = correct;
    end
    check("judge_result_ok", 32'(o_result_ok), 32'(ok));
    check("judge_result_fail", 32'(o_result_fail), 32'(!ok));
    check("judge_target_valid", 32'(o_target_valid), 32'd0);
    if (ok) begin
      inc = (BONUS && m_streak == 2) ? 2 : 1;
      m_score  = (m_score + inc > smax) ? smax : m_score + inc;
      m_streak = (inc == 2) ? 0 : m_streak + 1;
    end else begin
      m_streak = 0;
    end
    last = (m_round == rounds - 1);
    if (!last) m_round++;
    tick();
    check("post_result_ok", 32'(o_result_ok), 32'd0);
    check("post_result_fail", 32'(o_result_fail), 32'd0);
    check("score", 32'(o_score), 32'(m_score));
    check("round_idx", 32'(o_round), 32'(m_round));
    check("game_over", 32'(o_game_over), 32'(last));
`ifdef GAME_STREAK_BONUS_EN
    check("streak", 32'(o_streak), 32'(m_streak));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gen_enable"}, 32'(o_gen_enable), 32'd0);
    check({tag, "_target"}, 32'(o_target), 32'd0);
    check({tag, "_target_valid"}, 32'(o_target_valid), 32'd0);
    check({tag, "_timer"}, 32'(o_timer), 32'd0);
    check({tag, "_round_idx"}, 32'(o_round), 32'd0);
    check({tag, "_score"}, 32'(o_score), 32'd0);
    check({tag, "_result_ok"}, 32'(o_result_ok), 32'd0);
    check({tag, "_result_fail"}, 32'(o_result_fail), 32'd0);
    check({tag, "_game_over"}, 32'(o_game_over), 32'd0);
  endtask

  initial begin
    int d;
    logic [3:0] sc;
    rst = 1'b1; start = 1'b0; submit = 1'b0; gen_result = 4'h0; guess = 4'h0;
    model_clear();
    tick(); tick();
    rst = 1'b0;
    tick();
    check_all_zero("reset");
    tick();
    check("idle_stays_gen_enable", 32'(o_gen_enable), 32'd0);

    // correct guess on a forced target, then a wrong guess, then another correct one
    do_start();
    play_round(3, 1'b1, 1'b0, 1'b1, 4'b1011, 4'h0);
    play_round(int'($urandom_range(0, TL)), 1'b0, 1'b1, 1'b1, 4'b1011, 4'b0110);
    play_round(int'($urandom_range(0, TL)), 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    check("score_before_reset", 32'(o_score), 32'd2);

    // reset in the middle of WAIT clears everything without a clock edge
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 4; i++) tick();
    check("midwait_target_valid", 32'(o_target_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    tick();
    rst = 1'b0;
    model_clear();
    tick();
    check("after_reset_idle_gen_enable", 32'(o_gen_enable), 32'd0);
    check("after_reset_idle_game_over", 32'(o_game_over), 32'd0);

    // timeout round, submit exactly at timer==0, then two more correct rounds
    do_start();
    play_round(-1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    play_round(TL, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    play_round(int'($urandom_range(0, TL)), 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    play_round(int'($urandom_range(0, TL)), 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);

    // four correct rounds to game over; submit in DONE ignored; start restarts
    do_start();
    for (int r = 0; r < 4; r++)
      play_round(int'($urandom_range(0, TL)), 1'b1, r[0], 1'b0, 4'h0, 4'h0);
    check("full_game_score", 32'(o_score), BONUS ? 32'd5 : 32'd4);
    sc = o_score;
    guess = o_target;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    check("done_submit_result_ok", 32'(o_result_ok), 32'd0);
    tick();
    check("done_submit_game_over", 32'(o_game_over), 32'd1);
    check("done_submit_score", 32'(o_score), 32'(m_score));
    do_start();
    check("restart_score", 32'(o_score), 32'd0);
    check("restart_round", 32'(o_round), 32'd0);
    check("restart_game_over", 32'(o_game_over), 32'd0);
    check("restart_gen_enable", 32'(o_gen_enable), 32'd1);

    // random game: random outcome and response time per round
    for (int r = 0; r < 4; r++) begin
      d = int'($urandom_range(0, TL + 1));
      play_round((d > TL) ? -1 : d, bit'($urandom_range(0, 1)), 1'b0, 1'b0, 4'h0, 4'($urandom));
    end

    // 2-bit score instance: eight correct rounds saturate the score at 3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sel = 1'b1;
    model_clear();
    tick();
    do_start();
    for (int r = 0; r < 8; r++)
      play_round(int'($urandom_range(0, TL)), 1'b1, (r == 2), 1'b0, 4'h0, 4'h0);
    check("saturated_score", 32'(o_score), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run always ends with a summary line.
  initial begin
    #200000;
    miscompares++;
    $display("FAIL timeout observed=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
